up_count_timer: RTL and testbench
=================================

Name: up_count_timer

Overview:
- Programmable up-counting timer; the count-up counterpart of the team's free-running 4-bit down counter.
- Counts from 0 up to a latched limit under a start/stop/pause control FSM, then flags completion.
- Used as the interval/timeout source alongside the down counters in the counter library; single clock domain.

Parameters:
- WIDTH, 4, width of count and limit in bits (minimum 2).

Ports:
- clk     input   1      clock; all state changes on posedge.
- reset   input   1      synchronous, active-low reset (reset==0 at posedge resets the block).
- start   input   1      level sampled each posedge; latch limit and begin counting from 0.
- stop    input   1      level; abort the current run and return to IDLE.
- pause   input   1      level; hold count while in RUN/PAUSE.
- limit   input   WIDTH  terminal count; sampled only on an accepted start.
- count   output  WIDTH  current count value (registered).
- busy    output  1      1 in RUN or PAUSE.
- paused  output  1      1 in PAUSE.
- done    output  1      terminal-count flag (registered).

Behaviour:
- Interface: clock clk; reset is synchronous, active-low (reset==0 sampled at posedge clk).
- Reset (any state, mid-run included): state=IDLE, count=0, lim_q=0, busy=0, paused=0, done=0. No asynchronous path.
- States: IDLE, RUN, PAUSE, DONE. busy and paused decode from the state register; count and done are registered.
- Priority at each posedge: reset > stop > start > pause > increment.
- IDLE: count holds 0. start=1 -> lim_q<=limit, count<=0, go to RUN. If limit==0, go straight to DONE with done<=1.
- RUN, pause=0: count<=count+1.
  - If count+1==lim_q: go to DONE and done<=1 on the same edge. count and done become visible together.
  - Latency: start edge gives count=0; L edges later count=L and done=1.
- RUN, pause=1: count holds; go to PAUSE.
- PAUSE, pause=1: hold.
- PAUSE, pause=0: increment exactly as in RUN on that edge, including the terminal check; go to RUN or DONE.
- DONE (non-reload build): count holds lim_q; done=1 as a level until start, stop or reset.
  - start=1 restarts: count<=0, relatch limit, done<=0.
  - stop=1 -> IDLE with count<=0, done<=0.
- start while in RUN or PAUSE: restart (count<=0, relatch limit, state RUN, pause ignored that edge). An in-flight done is never produced.
- stop in RUN, PAUSE or DONE -> IDLE, count<=0, done<=0. stop in IDLE: no effect. stop together with start: stop wins.
- start together with pause in IDLE: start wins, enters RUN; pause is acted on from the next edge.
- limit changes outside an accepted start are ignored (lim_q latched).
- Width/wrap: unsigned modulo-2^WIDTH arithmetic. limit=all-ones counts to 2^WIDTH-1 and stops; count never wraps to 0 in the non-reload build.

Optional Feature:
- Macro: UPCNT_AUTORELOAD_EN.
- Defined: reaching lim_q does not enter DONE.
  - State stays RUN; done is a 1-cycle pulse on the edge count becomes lim_q.
  - Next increment edge loads count<=0 (period lim_q+1 cycles).
  - limit==0 at start: done pulses every cycle with count=0.
  - busy stays 1 until stop or reset.
- Undefined: DONE state and level done as described above.

Test Plan:
- Reset: hold reset=0 for 2 edges with start=1 -> count=0000, busy=0, done=0. Release reset=1 -> stays IDLE until start.
- Basic run, WIDTH=4: limit=5, start pulse 1 cycle.
  - count 0,1,2,3,4,5 on consecutive edges; done=1 and busy=0 on the edge count=5.
  - count holds 5 for 10 more cycles.
- Pause: limit=8, pause=1 for 3 cycles when count=3 -> count stays 3 and paused=1 for 3 cycles. After release, count resumes 4..8 and done asserts at 8.
- Restart and abort:
  - start mid-run at count=6 (limit=9), new limit=2 -> count 0,1,2 then done.
  - stop at count=1 -> IDLE, count=0.
  - stop+start on the same edge -> IDLE.
- Boundaries: limit=0 -> done=1 one edge after start, count=0. limit=1111 -> count reaches 1111, done=1, no wrap. reset=0 at count=7 -> count=0, IDLE next edge.
- With UPCNT_AUTORELOAD_EN, limit=3:
  - count 0,1,2,3,0,1,2,3...; done high only on the count=3 cycles; busy=1 throughout.
  - stop -> IDLE, count=0.

Source files
------------

// File: rtl/up_count_timer.sv
// Programmable up-counting timer: counts 0..limit under start/stop/pause control.
// Build with UPCNT_AUTORELOAD_EN defined to wrap to 0 after the limit instead of stopping.
module up_count_timer #(
  parameter int unsigned WIDTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             stop,
  input  logic             pause,
  input  logic [WIDTH-1:0] limit,
  output logic [WIDTH-1:0] count,
  output logic             busy,
  output logic             paused,
  output logic             done
);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    PAUSE,
    DONE
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] count_d;
  logic [WIDTH-1:0] lim_q, lim_d;
  logic             done_d;
  logic [WIDTH-1:0] count_inc;
  logic [WIDTH-1:0] count_adv;

  assign count_inc = count + WIDTH'(1);

`ifdef UPCNT_AUTORELOAD_EN
  // Wrapping at lim_q (rather than at 2^WIDTH) gives a period of lim_q+1 edges.
  assign count_adv = (count == lim_q) ? '0 : count_inc;
`else
  assign count_adv = count_inc;
`endif

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= IDLE;
      count   <= '0;
      lim_q   <= '0;
      done    <= 1'b0;
    end else begin
      state_q <= state_d;
      count   <= count_d;
      lim_q   <= lim_d;
      done    <= done_d;
    end
  end

  always_comb begin
    state_d = state_q;
    count_d = count;
    lim_d   = lim_q;
    done_d  = done;

    if (stop) begin
      state_d = IDLE;
      count_d = '0;
      done_d  = 1'b0;
    end else if (start) begin
      lim_d   = limit;
      count_d = '0;
`ifdef UPCNT_AUTORELOAD_EN
      state_d = RUN;
      done_d  = (limit == '0);
`else
      if (limit == '0) begin
        state_d = DONE;
        done_d  = 1'b1;
      end else begin
        state_d = RUN;
        done_d  = 1'b0;
      end
`endif
    end else begin
      case (state_q)
        RUN, PAUSE: begin
          if (pause) begin
            state_d = PAUSE;
            done_d  = 1'b0;
          end else begin
            count_d = count_adv;
`ifdef UPCNT_AUTORELOAD_EN
            state_d = RUN;
            done_d  = (count_adv == lim_q);
`else
            if (count_adv == lim_q) begin
              state_d = DONE;
              done_d  = 1'b1;
            end else begin
              state_d = RUN;
              done_d  = 1'b0;
            end
`endif
          end
        end
        default: begin
        end
      endcase
    end
  end

  assign busy   = (state_q == RUN) || (state_q == PAUSE);
  assign paused = (state_q == PAUSE);

endmodule

// File: tb/tb_up_count_timer.sv
// Self-checking bench for up_count_timer: directed scenarios then random stimulus,
// compared every edge against a behavioural model of the timer.
module tb_up_count_timer;

  localparam int unsigned WIDTH = 4;

  logic             clk = 1'b0;
  logic             reset;
  logic             start;
  logic             stop;
  logic             pause;
  logic [WIDTH-1:0] limit;
  logic [WIDTH-1:0] count;
  logic             busy;
  logic             paused;
  logic             done;

  int tests = 0;
  int fails = 0;

  // Reference model: plain integers and flags
  int m_cnt  = 0;
  int m_lim  = 0;
  bit m_act  = 1'b0;
  bit m_held = 1'b0;
  bit m_done = 1'b0;

  up_count_timer #(.WIDTH(WIDTH)) dut (
    .clk    (clk),
    .reset  (reset),
    .start  (start),
    .stop   (stop),
    .pause  (pause),
    .limit  (limit),
    .count  (count),
    .busy   (busy),
    .paused (paused),
    .done   (done)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp)
    else begin
      fails++;
      $error("FAIL %s: observed %0d expected %0d (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  task automatic model_edge(input bit r, input bit sp, input bit st, input bit pa, input int lim);
    if (!r) begin
      m_cnt = 0; m_lim = 0; m_act = 0; m_held = 0; m_done = 0;
    end else if (sp) begin
      m_cnt = 0; m_act = 0; m_held = 0; m_done = 0;
    end else if (st) begin
      m_lim  = lim;
      m_cnt  = 0;
      m_held = 0;
`ifdef UPCNT_AUTORELOAD_EN
      m_act  = 1;
      m_done = (lim == 0);
`else
      m_act  = (lim != 0);
      m_done = (lim == 0);
`endif
    end else if (m_act) begin
      if (pa) begin
        m_held = 1;
        m_done = 0;
      end else begin
        m_held = 0;
`ifdef UPCNT_AUTORELOAD_EN
        m_cnt  = (m_cnt + 1) % (m_lim + 1);
        m_done = (m_cnt == m_lim);
`else
        m_cnt  = m_cnt + 1;
        if (m_cnt == m_lim) begin
          m_act  = 0;
          m_done = 1;
        end
`endif
      end
    end
  endtask

  task automatic step(input bit r, input bit sp, input bit st, input bit pa, input int lim);
    reset = r;
    stop  = sp;
    start = st;
    pause = pa;
    limit = lim[WIDTH-1:0];
    @(posedge clk);
    model_edge(r, sp, st, pa, lim);
    #1;
    check("count",  32'(count),  32'(m_cnt));
    check("busy",   32'(busy),   32'(m_act));
    check("paused", 32'(paused), 32'(m_act && m_held));
    check("done",   32'(done),   32'(m_done));
  endtask

  task automatic idle_steps(input int n);
    for (int i = 0; i < n; i++) step(1, 0, 0, 0, 0);
  endtask

  initial begin
    // reset held with start asserted
    step(0, 0, 1, 0, 5);
    step(0, 0, 1, 0, 5);
    idle_steps(3);

    // basic run to 5, then hold
    step(1, 0, 1, 0, 5);
    idle_steps(15);

    // pause for 3 cycles at count 3
    step(1, 0, 1, 0, 8);
    idle_steps(3);
    for (int i = 0; i < 3; i++) step(1, 0, 0, 1, 0);
    idle_steps(8);

    // restart mid-run with a new limit
    step(1, 0, 1, 0, 9);
    idle_steps(6);
    step(1, 0, 1, 1, 2);
    idle_steps(4);

    // stop mid-run, then stop+start together
    step(1, 0, 1, 0, 7);
    idle_steps(1);
    step(1, 1, 0, 0, 0);
    idle_steps(2);
    step(1, 1, 1, 0, 3);
    idle_steps(2);

    // limit 0, limit all-ones, limit ignored outside start
    step(1, 0, 1, 0, 0);
    idle_steps(3);
    step(1, 0, 1, 0, 15);
    for (int i = 0; i < 18; i++) step(1, 0, 0, 0, 3);

    // reset mid-run at count 7
    step(1, 0, 1, 0, 12);
    idle_steps(7);
    step(0, 0, 0, 0, 0);
    idle_steps(2);

    // start with pause in IDLE
    step(1, 1, 0, 0, 0);
    step(1, 0, 1, 1, 3);
    step(1, 0, 0, 1, 3);
    idle_steps(6);

    // randomized traffic
    for (int i = 0; i < 600; i++) begin
      bit r, sp, st, pa;
      int lim;
      r   = ($urandom_range(0, 99) >= 2);
      sp  = ($urandom_range(0, 99) < 4);
      st  = ($urandom_range(0, 99) < 7);
      pa  = ($urandom_range(0, 99) < 25);
      lim = ($urandom_range(0, 9) == 0) ? int'($urandom_range(0, 15)) : int'($urandom_range(0, 6));
      step(r, sp, st, pa, lim);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
